// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with write-back mux, WB->EX forwarding and retirement counters
module mem_wb_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  Valid_Mem,
  input  logic                  Reg_Write_Mem,
  input  logic [REG_ADDR_W-1:0] Rd_Mem,
  input  logic                  Write_Back_Sel_Mem,
  input  logic [DATA_W-1:0]     Mem_Out,
  input  logic [DATA_W-1:0]     Alu_Out_Mem,
  input  logic [REG_ADDR_W-1:0] Rs1_EX,
  input  logic [REG_ADDR_W-1:0] Rs2_EX,
  output logic                  Valid_WB,
  output logic                  Reg_Write_WB,
  output logic [REG_ADDR_W-1:0] Rd_WB,
  output logic [DATA_W-1:0]     Write_Data_WB,
  output logic                  Fwd1_Hit,
  output logic                  Fwd2_Hit,
  output logic [DATA_W-1:0]     Fwd_Data,
  output logic [CNT_W-1:0]      Retired_Count,
  output logic [CNT_W-1:0]      Load_Count
);
  logic                  valid_q, valid_d, rw_q, rw_d, cap, ret;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [CNT_W-1:0]      ret_q, ret_d, ldc_q, ldc_d;
  always_comb begin
    cap     = !Flush && !Stall;
    ret     = cap && Valid_Mem;
    valid_d = Flush ? 1'b0 : Stall ? valid_q : Valid_Mem;
    // gating with Valid_Mem keeps an X write-enable on a bubble out of the register
    rw_d    = Flush ? 1'b0 : Stall ? rw_q : (Valid_Mem && Reg_Write_Mem);
    rd_d    = cap ? Rd_Mem : rd_q;
    data_d  = cap ? (Write_Back_Sel_Mem ? Mem_Out : Alu_Out_Mem) : data_q;
    ret_d   = ret_q + CNT_W'(ret);
    ldc_d   = ldc_q + CNT_W'(ret && Write_Back_Sel_Mem);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      ret_q   <= '0;
      ldc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      ret_q   <= ret_d;
      ldc_q   <= ldc_d;
    end
  end
  assign Valid_WB      = valid_q;
  assign Reg_Write_WB  = valid_q && rw_q && (rd_q != '0);
  assign Rd_WB         = rd_q;
  assign Write_Data_WB = data_q;
  assign Fwd1_Hit      = Reg_Write_WB && (rd_q == Rs1_EX);
  assign Fwd2_Hit      = Reg_Write_WB && (rd_q == Rs2_EX);
  assign Fwd_Data      = data_q;
  assign Retired_Count = ret_q;
  assign Load_Count    = ldc_q;
endmodule
